// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the fetch / load-store memory port arbiter:
//   - requester owner encodings used in the response tag
//   - data and byte-enable widths of the RAM interface
//   - the response tag carried through the fixed-latency pipeline
//   - the grant decision encoding used by the top level
//   - make_tag(): builds the tag pushed for the current cycle's grant
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_STRB_W = 4;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    // One entry per granted access; valid=0 marks an empty slot.
    typedef struct packed {
        logic valid;
        logic owner;
        logic is_write;
    } rsp_tag_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

    // Tag for this cycle's grant. A fetch can never produce a write tag.
    function automatic rsp_tag_t make_tag(input grant_e grant, input logic d_we);
        rsp_tag_t tag;
        tag.valid    = (grant != GNT_NONE);
        tag.owner    = (grant == GNT_D) ? OWNER_D : OWNER_IF;
        tag.is_write = (grant == GNT_D) & d_we;
        return tag;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_pipe.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_tag_pipe
// DEPTH-stage shift register of response tags. A tag entering at tag_in
// appears at tag_out DEPTH clock edges later, lining up with the RAM read
// data of the access it describes.
// Ports:
//   clk     in  clock, rising edge
//   clr_n   in  synchronous active-low clear of every stage
//   tag_in  in  tag of the access granted this cycle (valid=0 when idle)
//   tag_out out tag of the access whose RAM data is valid this cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     clr_n,
    input  rsp_tag_t tag_in,
    output rsp_tag_t tag_out
);

    rsp_tag_t stage_r [DEPTH];

    // Shift tags one stage per cycle; a clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported RAM between the core's fetch port (read only) and
// its load/store port. At most one request is granted per cycle; data has
// priority unless fetch has lost STARVE_LIMIT cycles in a row, in which case
// fetch wins once. Read data returns MEM_LATENCY cycles after the grant and is
// routed back to the requester that issued it; writes get a zero-data ack.
// Parameters:
//   AW           word-address width
//   MEM_LATENCY  cycles from grant to valid mem_rdata (1..4)
//   STARVE_LIMIT consecutive fetch losses before fetch takes priority; 0 = never
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   if_req_valid/ready/addr    fetch request handshake
//   if_rsp_valid/data          fetch read response (1-cycle pulse)
//   d_req_valid/ready/addr/we/wdata/wstrb  load/store request handshake
//   d_rsp_valid/data           load data or write ack (data 0)
//   mem_en/we/addr/wdata/wstrb RAM command for the granted request
//   mem_rdata                  RAM read data, MEM_LATENCY cycles after mem_en
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [AW-1:0]         if_req_addr,
    output logic                  if_rsp_valid,
    output logic [MEM_DATA_W-1:0] if_rsp_data,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [AW-1:0]         d_req_addr,
    input  logic                  d_req_we,
    input  logic [MEM_DATA_W-1:0] d_req_wdata,
    input  logic [MEM_STRB_W-1:0] d_req_wstrb,
    output logic                  d_rsp_valid,
    output logic [MEM_DATA_W-1:0] d_rsp_data,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    output logic [MEM_STRB_W-1:0] mem_wstrb,
    input  logic [MEM_DATA_W-1:0] mem_rdata
);

    // Counter must hold 0..STARVE_LIMIT; keep at least one bit when the guard is off.
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic             out_en_r;
    logic [CNT_W-1:0] starve_cnt_r;
    logic             grant_en_s;
    logic             starve_hit_s;
    grant_e           grant_s;
    rsp_tag_t         tag_in_s;
    rsp_tag_t         tag_out_s;
    logic             rsp_live_s;

    // Grants stay off during reset and for the first cycle after release:
    // out_en_r only rises on the first edge that samples reset high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_en_r <= 1'b0;
        end else begin
            out_en_r <= 1'b1;
        end
    end

    // Gating with the live reset input keeps mem_en low in a reset cycle,
    // so a write presented then never reaches the RAM.
    assign grant_en_s   = reset & out_en_r;
    assign starve_hit_s = (STARVE_LIMIT != 0) && (starve_cnt_r == STARVE_MAX);

    // Fixed priority arbiter: data first, fetch first once starvation is hit.
    always_comb begin
        grant_s = GNT_NONE;
        if (!grant_en_s) begin
            grant_s = GNT_NONE;
        end else if (d_req_valid && !(if_req_valid && starve_hit_s)) begin
            grant_s = GNT_D;
        end else if (if_req_valid) begin
            grant_s = GNT_IF;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // Drive the RAM command and readies from whichever requester won.
    always_comb begin
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = {AW{1'b0}};
        mem_wdata    = {MEM_DATA_W{1'b0}};
        mem_wstrb    = {MEM_STRB_W{1'b0}};
        case (grant_s)
            GNT_IF: begin
                if_req_ready = 1'b1;
                mem_en       = 1'b1;
                mem_addr     = if_req_addr;
            end
            GNT_D: begin
                d_req_ready = 1'b1;
                mem_en      = 1'b1;
                mem_we      = d_req_we;
                mem_addr    = d_req_addr;
                mem_wdata   = d_req_wdata;
                mem_wstrb   = d_req_wstrb;
            end
            default: begin
                mem_en = 1'b0;
                mem_we = 1'b0;
            end
        endcase
    end

    // Count consecutive cycles in which fetch wanted the RAM but lost;
    // any fetch grant or idle fetch cycle restarts the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!if_req_valid || (grant_s == GNT_IF)) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (starve_cnt_r != STARVE_MAX) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign tag_in_s = make_tag(grant_s, d_req_we);

    mem_port_arbiter_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .clr_n   (reset),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    // The pipeline still shows stale tags during the reset cycle itself;
    // mask them so no response pulses while reset is low.
    assign rsp_live_s = reset & tag_out_s.valid;

    // Route the completing access back to its owner; writes ack with zero data.
    always_comb begin
        if_rsp_valid = 1'b0;
        d_rsp_valid  = 1'b0;
        if_rsp_data  = {MEM_DATA_W{1'b0}};
        d_rsp_data   = {MEM_DATA_W{1'b0}};
        if (rsp_live_s && (tag_out_s.owner == OWNER_IF)) begin
            if_rsp_valid = 1'b1;
            if_rsp_data  = mem_rdata;
        end else if (rsp_live_s && (tag_out_s.owner == OWNER_D)) begin
            d_rsp_valid = 1'b1;
            d_rsp_data  = tag_out_s.is_write ? {MEM_DATA_W{1'b0}} : mem_rdata;
        end else begin
            if_rsp_valid = 1'b0;
            d_rsp_valid  = 1'b0;
        end
    end

endmodule
